// File: rtl/counters_pkg.sv
// Shared types and defaults for the counters library.
package counters_pkg;

    localparam int DCNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dcnt_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides an enable stream by PRESCALE: one tick per PRESCALE enabled cycles.
// Only compiled when DOWN_CNT_PRESCALE_EN is defined.
`ifdef DOWN_CNT_PRESCALE_EN
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en_in,
    output logic tick_out
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] TOP = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    // Down-counter: the enabled cycle that finds it at zero is the tick.
    assign tick_out = en_in && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= TOP;
        end else if (clr) begin
            cnt <= TOP;
        end else if (en_in) begin
            cnt <= (cnt == '0) ? TOP : cnt - PW'(1);
        end
    end

endmodule
`endif

// File: rtl/sync_down_counter.sv
// Loadable down counter with terminal-count pulse, one-shot or auto-reload.
// Optional enable prescaler selected by DOWN_CNT_PRESCALE_EN.
//
//   state | meaning
//   IDLE  | after reset, waiting for the first load
//   RUN   | counting down on each tick
//   DONE  | reached zero (or loaded with 0), holding until the next load
module sync_down_counter
    import counters_pkg::*;
#(
    parameter int WIDTH    = DCNT_WIDTH,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("sync_down_counter: PRESCALE must be >= 1");
    end

    dcnt_state_t      state, state_nxt;
    logic [WIDTH-1:0] reload_reg, reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             tick;

`ifdef DOWN_CNT_PRESCALE_EN
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (load),
        .en_in    (enable),
        .tick_out (tick)
    );
`else
    assign tick = enable;
`endif

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        tc_nxt     = 1'b0;
        // Load always wins over a coincident tick.
        if (load) begin
            count_nxt  = load_val;
            reload_nxt = load_val;
            state_nxt  = (load_val != '0) ? RUN : DONE;
        end else if (tick && (state == RUN)) begin
            if (count > ONE) begin
                count_nxt = count - ONE;
            end else if (count == ONE) begin
                count_nxt = '0;
                tc_nxt    = 1'b1;
            end else if (auto_reload && (reload_reg != '0)) begin
                count_nxt = reload_reg;
            end else begin
                state_nxt = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            tc         <= tc_nxt;
            busy       <= (state_nxt == RUN);
        end
    end

endmodule
